// File: rtl/riscuinho_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU among NUM_CORES RISCuinho cores (IDLE -> BUSY -> RESP).
// Optional watchdog on the FPU handshake is built when FPU_ARB_TIMEOUT_EN is defined.
module riscuinho_fpu_arbiter #(
    parameter int NUM_CORES      = 2,
    parameter int XLEN           = 32,
    parameter int OP_W           = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      core_req,
    input  logic [NUM_CORES*XLEN-1:0] core_op_a,
    input  logic [NUM_CORES*XLEN-1:0] core_op_b,
    input  logic [NUM_CORES*OP_W-1:0] core_op,
    output logic [NUM_CORES-1:0]      core_done,
    output logic [NUM_CORES-1:0]      core_err,
    output logic [NUM_CORES*XLEN-1:0] core_result,
    output logic [((NUM_CORES <= 2) ? 1 : $clog2(NUM_CORES))-1:0] grant_id,
    output logic                      busy,
    output logic                      fpu_req,
    output logic [XLEN-1:0]           fpu_op_a,
    output logic [XLEN-1:0]           fpu_op_b,
    output logic [OP_W-1:0]           fpu_op,
    input  logic                      fpu_ack,
    input  logic [XLEN-1:0]           fpu_result
);
    localparam int GW = (NUM_CORES <= 2) ? 1 : $clog2(NUM_CORES);

    // Handshake: a core holds core_req and its operands stable until its one-cycle
    // core_done pulse; the FPU sees fpu_req held high until it returns fpu_ack.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   win_idx;
    logic            win_found;
    logic            expired;
    logic            err_q;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    assign expired = (state == S_BUSY) && (tmo_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || state != S_BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign expired        = 1'b0;
`endif

    // Search begins just after the previous winner, so the last finisher ranks lowest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            if (!win_found && core_req[(int'(last_grant) + i) % NUM_CORES]) begin
                win_found = 1'b1;
                win_idx   = GW'((int'(last_grant) + i) % NUM_CORES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (win_found) state_next = S_BUSY;
            S_BUSY:  if (fpu_ack || expired) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id    <= '0;
            last_grant  <= GW'(NUM_CORES - 1);
            fpu_op_a    <= '0;
            fpu_op_b    <= '0;
            fpu_op      <= '0;
            core_result <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_id   <= win_idx;
                        last_grant <= win_idx;
                        fpu_op_a   <= core_op_a[int'(win_idx)*XLEN +: XLEN];
                        fpu_op_b   <= core_op_b[int'(win_idx)*XLEN +: XLEN];
                        fpu_op     <= core_op[int'(win_idx)*OP_W +: OP_W];
                    end
                end
                S_BUSY: begin
                    // An ack in the expiry cycle still counts as a normal completion.
                    if (fpu_ack) begin
                        core_result[int'(grant_id)*XLEN +: XLEN] <= fpu_result;
                        err_q <= 1'b0;
                    end else if (expired) begin
                        core_result[int'(grant_id)*XLEN +: XLEN] <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        busy      = (state != S_IDLE);
        fpu_req   = (state == S_BUSY);
        core_done = '0;
        core_err  = '0;
        if (state == S_RESP) begin
            core_done[grant_id] = 1'b1;
            core_err[grant_id]  = err_q;
        end
    end

endmodule

// File: tb/tb_riscuinho_fpu_arbiter.sv
// Directed bench for riscuinho_fpu_arbiter with NUM_CORES=4; watchdog steps run when
// FPU_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_riscuinho_fpu_arbiter;
    localparam int N    = 4;
    localparam int XLEN = 32;
    localparam int OP_W = 3;

    logic              clk;
    logic              rst;
    logic [N-1:0]      core_req;
    logic [N*XLEN-1:0] core_op_a;
    logic [N*XLEN-1:0] core_op_b;
    logic [N*OP_W-1:0] core_op;
    logic [N-1:0]      core_done;
    logic [N-1:0]      core_err;
    logic [N*XLEN-1:0] core_result;
    logic [1:0]        grant_id;
    logic              busy;
    logic              fpu_req;
    logic [XLEN-1:0]   fpu_op_a;
    logic [XLEN-1:0]   fpu_op_b;
    logic [OP_W-1:0]   fpu_op;
    logic              fpu_ack;
    logic [XLEN-1:0]   fpu_result;

    int n_checks;
    int n_fail;
    int done_cnt[N];

    riscuinho_fpu_arbiter #(
        .NUM_CORES(N), .XLEN(XLEN), .OP_W(OP_W), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .core_req(core_req),
        .core_op_a(core_op_a), .core_op_b(core_op_b), .core_op(core_op),
        .core_done(core_done), .core_err(core_err), .core_result(core_result),
        .grant_id(grant_id), .busy(busy), .fpu_req(fpu_req),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_op(fpu_op),
        .fpu_ack(fpu_ack), .fpu_result(fpu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        core_op_a[k*XLEN +: XLEN] = a;
        core_op_b[k*XLEN +: XLEN] = b;
        core_op[k*OP_W +: OP_W]   = op;
    endtask

    function automatic logic [31:0] res(input int k);
        return core_result[k*XLEN +: XLEN];
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        for (int k = 0; k < N; k++) done_cnt[k] = 0;
        rst        = 1'b1;
        core_req   = '0;
        core_op_a  = '0;
        core_op_b  = '0;
        core_op    = '0;
        fpu_ack    = 1'b0;
        fpu_result = '0;

        // Reset values
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fpu_req", 64'(fpu_req), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_done", 64'(core_done), 64'd0);
        chk("rst_err", 64'(core_err), 64'd0);
        chk("rst_op_a", 64'(fpu_op_a), 64'd0);
        chk("rst_op", 64'(fpu_op), 64'd0);
        chk("rst_result", 64'(|core_result), 64'd0);
        rst = 1'b0;

        // Core 1 alone wins first after reset
        set_ops(1, 32'h1111_1111, 32'h2222_2222, 3'd5);
        core_req = 4'b0010;
        tick();
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_fpu_req", 64'(fpu_req), 64'd1);
        chk("c1_grant", 64'(grant_id), 64'd1);
        chk("c1_op_a", 64'(fpu_op_a), 64'h1111_1111);
        chk("c1_op", 64'(fpu_op), 64'd5);
        fpu_ack    = 1'b1;
        fpu_result = 32'hAAAA_0001;
        tick();
        chk("c1_done", 64'(core_done), 64'b0010);
        chk("c1_result", 64'(res(1)), 64'hAAAA_0001);
        chk("c1_req_drop", 64'(fpu_req), 64'd0);
        fpu_ack  = 1'b0;
        core_req = '0;
        tick();
        chk("c1_idle_done", 64'(core_done), 64'd0);
        chk("c1_idle_busy", 64'(busy), 64'd0);

        // Single transaction from core 0 with operand change during BUSY
        set_ops(0, 32'h3F80_0000, 32'h4000_0000, 3'b000);
        core_req = 4'b0001;
        tick();
        chk("s0_grant", 64'(grant_id), 64'd0);
        chk("s0_op_a", 64'(fpu_op_a), 64'h3F80_0000);
        chk("s0_op_b", 64'(fpu_op_b), 64'h4000_0000);
        chk("s0_op", 64'(fpu_op), 64'd0);
        core_op_a[0 +: XLEN] = 32'hDEAD_BEEF;
        tick();
        chk("s0_hold_op_a", 64'(fpu_op_a), 64'h3F80_0000);
        chk("s0_no_done_yet", 64'(core_done), 64'd0);
        fpu_ack    = 1'b1;
        fpu_result = 32'h4040_0000;
        tick();
        chk("s0_done", 64'(core_done), 64'b0001);
        chk("s0_err", 64'(core_err), 64'd0);
        chk("s0_result0", 64'(res(0)), 64'h4040_0000);
        chk("s0_result1_kept", 64'(res(1)), 64'hAAAA_0001);
        fpu_ack  = 1'b0;
        core_req = '0;
        tick();

        // Fairness: reset, then all cores request with zero-latency ack
        rst = 1'b1;
        tick();
        tick();
        chk("f_rst_result", 64'(|core_result), 64'd0);
        rst      = 1'b0;
        core_req = 4'b1111;
        fpu_ack  = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            fpu_result = 32'h1000_0000 + 32'(i);
            tick();
            chk("f_grant", 64'(grant_id), 64'(i % N));
            chk("f_fpu_req", 64'(fpu_req), 64'd1);
            tick();
            chk("f_done", 64'(core_done), 64'(4'b0001 << (i % N)));
            chk("f_result", 64'(res(i % N)), 64'(32'h1000_0000 + 32'(i)));
            for (int k = 0; k < N; k++) if (core_done[k]) done_cnt[k]++;
            tick();
            chk("f_idle", 64'(busy), 64'd0);
        end
        core_req = '0;
        fpu_ack  = 1'b0;
        for (int k = 0; k < N; k++) chk("f_done_count", 64'(done_cnt[k]), 64'd2);
        tick();

        // Reset while BUSY, then a late ack in IDLE
        core_req = 4'b0100;
        tick();
        chk("r_grant", 64'(grant_id), 64'd2);
        chk("r_fpu_req", 64'(fpu_req), 64'd1);
        rst = 1'b1;
        tick();
        chk("r_fpu_req_drop", 64'(fpu_req), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_no_done", 64'(core_done), 64'd0);
        rst        = 1'b0;
        core_req   = '0;
        fpu_ack    = 1'b1;
        fpu_result = 32'h7777_7777;
        tick();
        chk("r_late_ack_busy", 64'(busy), 64'd0);
        tick();
        chk("r_late_ack_done", 64'(core_done), 64'd0);
        chk("r_late_ack_result", 64'(res(2)), 64'd0);
        fpu_ack = 1'b0;
        tick();

`ifdef FPU_ARB_TIMEOUT_EN
        // Ack coinciding with watchdog expiry completes normally
        core_req = 4'b1000;
        tick();
        chk("t_grant", 64'(grant_id), 64'd3);
        for (int c = 0; c < 8; c++) tick();
        chk("t_still_busy", 64'(fpu_req), 64'd1);
        fpu_ack    = 1'b1;
        fpu_result = 32'h5555_5555;
        tick();
        chk("ta_done", 64'(core_done), 64'b1000);
        chk("ta_err", 64'(core_err), 64'd0);
        chk("ta_result", 64'(res(3)), 64'h5555_5555);
        fpu_ack  = 1'b0;
        core_req = '0;
        tick();

        // Watchdog expiry with no ack
        core_req = 4'b1000;
        tick();
        chk("to_fpu_req", 64'(fpu_req), 64'd1);
        for (int c = 0; c < 8; c++) tick();
        chk("to_no_done_yet", 64'(core_done), 64'd0);
        tick();
        chk("to_done", 64'(core_done), 64'b1000);
        chk("to_err", 64'(core_err), 64'b1000);
        chk("to_result", 64'(res(3)), 64'd0);
        core_req = '0;
        tick();
        chk("to_idle", 64'(busy), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
